// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_arbiter
//  Purpose  : Shares the byte-wide RAM/IO bus between the instruction-fetch
//             port and the data (load/store) port. Each 1/2/4-byte request is
//             serialised into byte transfers; little-endian read data is
//             reassembled. IO writes are throttled by i_io_buffer_full and the
//             whole block freezes while i_rdy is low.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst            clock, asynchronous active-high reset
//    i_rdy               global ready (low = freeze, no writes)
//    i_jump_flush        abort an in-flight instruction fetch
//    i_if_req/i_if_addr  fetch request (always 4 bytes), held until o_if_done
//    o_if_done/o_if_data 1-cycle done pulse with assembled instruction
//    i_dm_req/_we/_size  data request (size 00 byte, 01 half, 1x word)
//    i_dm_addr/_wdata    data address and store data (byte 0 in [7:0])
//    o_dm_done/_rdata    1-cycle done pulse with zero-extended load data
//    i_mem_din           read byte from memory (1-cycle latency)
//    o_mem_dout/_a/_wr   write byte, byte address, write strobe
//    i_io_buffer_full    IO transmit buffer full, holds IO write bytes
// ============================================================================
module mem_bus_arbiter #(
  parameter int         ADDR_W = 32,
  parameter logic [1:0] IO_SEL = 2'b11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_rdy,
  input  logic              i_jump_flush,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_done,
  output logic [31:0]       o_if_data,
  input  logic              i_dm_req,
  input  logic              i_dm_we,
  input  logic [1:0]        i_dm_size,
  input  logic [ADDR_W-1:0] i_dm_addr,
  input  logic [31:0]       i_dm_wdata,
  output logic              o_dm_done,
  output logic [31:0]       o_dm_rdata,
  input  logic [7:0]        i_mem_din,
  output logic [7:0]        o_mem_dout,
  output logic [ADDR_W-1:0] o_mem_a,
  output logic              o_mem_wr,
  input  logic              i_io_buffer_full
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_IF_RD = 2'd1,
    S_DM_RD = 2'd2,
    S_DM_WR = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_mem_a;
  logic [31:0]       r_wdata;
  logic [31:0]       r_data;
  logic [7:0]        r_mem_dout;
  logic [2:0]        r_cnt;
  logic [2:0]        r_len;
  logic              r_if_done;
  logic              r_dm_done;

  logic [2:0]        w_cnt_inc;
  logic [2:0]        w_old_idx;
  logic [2:0]        w_dm_len;
  logic [ADDR_W-1:0] w_next_a;
  logic [ADDR_W-1:0] w_old_a;
  logic              w_is_rd;
  logic              w_io_block;
  logic              w_acc_dm;
  logic              w_acc_if;
  logic              w_rd_step;
  logic              w_rd_fin;
  logic              w_wr_issue;

  // r_cnt counts edges since accept for reads (byte r_cnt is issued, byte
  // r_cnt-1 arrives on i_mem_din), and the current byte index for writes.
  assign w_cnt_inc  = r_cnt + 3'd1;
  assign w_old_idx  = (r_cnt == 3'd0) ? 3'd0 : (r_cnt - 3'd1);
  assign w_next_a   = r_addr + ADDR_W'(w_cnt_inc);
  assign w_old_a    = r_addr + ADDR_W'(w_old_idx);
  assign w_is_rd    = (r_state == S_IF_RD) || (r_state == S_DM_RD);
  assign w_io_block = (r_addr[17:16] == IO_SEL) && i_io_buffer_full;

  always_comb begin
    w_dm_len = 3'd4;
    case (i_dm_size)
      2'b00:   w_dm_len = 3'd1;
      2'b01:   w_dm_len = 3'd2;
      default: w_dm_len = 3'd4;
    endcase
  end

  // Next-state and per-cycle strobes
  always_comb begin
    w_state_nxt = r_state;
    w_acc_dm    = 1'b0;
    w_acc_if    = 1'b0;
    w_rd_step   = 1'b0;
    w_rd_fin    = 1'b0;
    w_wr_issue  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A port still showing its done pulse has not dropped its request yet
        if (i_rdy) begin
          if (i_dm_req && !r_dm_done) begin
            w_acc_dm    = 1'b1;
            w_state_nxt = i_dm_we ? S_DM_WR : S_DM_RD;
          end else if (i_if_req && !r_if_done) begin
            w_acc_if    = 1'b1;
            w_state_nxt = S_IF_RD;
          end
        end
      end
      S_IF_RD: begin
        if (i_rdy) begin
          if (i_jump_flush) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_rd_step = 1'b1;
            if (r_cnt == r_len) begin
              w_rd_fin    = 1'b1;
              w_state_nxt = S_IDLE;
            end
          end
        end
      end
      S_DM_RD: begin
        if (i_rdy) begin
          w_rd_step = 1'b1;
          if (r_cnt == r_len) begin
            w_rd_fin    = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_DM_WR: begin
        if (i_rdy && !w_io_block) begin
          w_wr_issue = 1'b1;
          if (w_cnt_inc == r_len) begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath; nothing moves while i_rdy is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr     <= '0;
      r_mem_a    <= '0;
      r_wdata    <= '0;
      r_data     <= '0;
      r_mem_dout <= '0;
      r_cnt      <= '0;
      r_len      <= '0;
      r_if_done  <= 1'b0;
      r_dm_done  <= 1'b0;
    end else if (i_rdy) begin
      r_if_done <= 1'b0;
      r_dm_done <= 1'b0;

      if (w_acc_dm || w_acc_if) begin
        r_addr  <= w_acc_dm ? i_dm_addr : i_if_addr;
        r_mem_a <= w_acc_dm ? i_dm_addr : i_if_addr;
        r_cnt   <= 3'd0;
        r_data  <= '0;
        r_len   <= w_acc_dm ? w_dm_len : 3'd4;
        if (w_acc_dm) begin
          r_wdata <= i_dm_wdata;
        end
        if (w_acc_dm && i_dm_we) begin
          r_mem_dout <= i_dm_wdata[7:0];
        end
      end

      if (w_rd_step) begin
        if (r_cnt != 3'd0) begin
          r_data[{w_old_idx[1:0], 3'b000} +: 8] <= i_mem_din;
        end
        if (w_rd_fin) begin
          if (r_state == S_IF_RD) begin
            r_if_done <= 1'b1;
          end else begin
            r_dm_done <= 1'b1;
          end
        end else begin
          r_cnt <= w_cnt_inc;
          if (w_cnt_inc < r_len) begin
            r_mem_a <= w_next_a;
          end
        end
      end

      if (w_wr_issue) begin
        if (w_cnt_inc == r_len) begin
          r_dm_done <= 1'b1;
        end else begin
          r_cnt      <= w_cnt_inc;
          r_mem_a    <= w_next_a;
          r_mem_dout <= r_wdata[{w_cnt_inc[1:0], 3'b000} +: 8];
        end
      end
    end
  end

  // During a read stall the bus re-presents the oldest uncaptured byte so
  // i_mem_din holds that byte when the clock resumes.
  assign o_mem_a    = (!i_rdy && w_is_rd) ? w_old_a : r_mem_a;
  assign o_mem_dout = r_mem_dout;
  assign o_mem_wr   = w_wr_issue;
  assign o_if_done  = r_if_done && i_rdy && !i_jump_flush;
  assign o_dm_done  = r_dm_done && i_rdy;
  assign o_if_data  = r_data;
  assign o_dm_rdata = r_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_bus_arbiter
//  Purpose  : Directed self-checking bench for mem_bus_arbiter with a
//             1-cycle-latency byte RAM model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        jump_flush;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        dm_req;
  logic        dm_we;
  logic [1:0]  dm_size;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_done;
  logic [31:0] dm_rdata;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_full;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  int ifd_cnt = 0;
  int dmd_cnt = 0;

  logic [7:0] ram [0:8191];

  mem_bus_arbiter #(.ADDR_W(32), .IO_SEL(2'b11)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_rdy            (rdy),
    .i_jump_flush     (jump_flush),
    .i_if_req         (if_req),
    .i_if_addr        (if_addr),
    .o_if_done        (if_done),
    .o_if_data        (if_data),
    .i_dm_req         (dm_req),
    .i_dm_we          (dm_we),
    .i_dm_size        (dm_size),
    .i_dm_addr        (dm_addr),
    .i_dm_wdata       (dm_wdata),
    .o_dm_done        (dm_done),
    .o_dm_rdata       (dm_rdata),
    .i_mem_din        (mem_din),
    .o_mem_dout       (mem_dout),
    .o_mem_a          (mem_a),
    .o_mem_wr         (mem_wr),
    .i_io_buffer_full (io_full)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_din <= ram[mem_a[12:0]];

  always @(negedge clk) begin
    if (mem_wr)  wr_cnt  = wr_cnt + 1;
    if (if_done) ifd_cnt = ifd_cnt + 1;
    if (dm_done) dmd_cnt = dmd_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Cycles from the current cycle until the selected done pulse is seen
  task automatic wait_done(input bit sel_dm, output int lat);
    bit seen;
    seen = 1'b0;
    lat  = -1;
    for (int i = 1; i <= 40 && !seen; i++) begin
      step();
      @(negedge clk);
      if (sel_dm ? dm_done : if_done) begin
        seen = 1'b1;
        lat  = i;
      end
    end
  endtask

  initial begin
    int lat;
    int w0, d0, dd0;
    bit seen;

    for (int i = 0; i < 8192; i++) ram[i] = 8'h00;
    ram[13'h100] = 8'h13; ram[13'h101] = 8'h05; ram[13'h102] = 8'h00; ram[13'h103] = 8'h00;
    ram[13'h104] = 8'h93; ram[13'h105] = 8'h00; ram[13'h106] = 8'h10; ram[13'h107] = 8'h00;
    ram[13'h200] = 8'h78; ram[13'h201] = 8'h56; ram[13'h202] = 8'h34; ram[13'h203] = 8'h12;
    ram[13'h1000] = 8'hEF; ram[13'h1001] = 8'hBE; ram[13'h1002] = 8'hAD; ram[13'h1003] = 8'hDE;

    rst = 1'b1; rdy = 1'b1; jump_flush = 1'b0; io_full = 1'b0;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_size = 2'b00; dm_addr = '0; dm_wdata = '0;

    // Reset state
    repeat (2) step();
    @(negedge clk);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_if_done", 32'(if_done), 32'd0);
    chk("rst_dm_done", 32'(dm_done), 32'd0);
    chk("rst_rdata", dm_rdata, 32'd0);
    step(); rst = 1'b0;

    // Word fetch from 0x100
    step(); if_req = 1'b1; if_addr = 32'h100;
    step(); @(negedge clk);
    chk("fetch_a0", mem_a, 32'h100);
    wait_done(1'b0, lat);
    chk("fetch_lat", 32'(lat), 32'd5);
    chk("fetch_data", if_data, 32'h0000_0513);
    step(); if_req = 1'b0;

    // Simultaneous fetch and load: data port first
    step(); if_req = 1'b1; if_addr = 32'h104;
    dm_req = 1'b1; dm_we = 1'b0; dm_size = 2'b10; dm_addr = 32'h200;
    step(); @(negedge clk);
    chk("prio_a0", mem_a, 32'h200);
    wait_done(1'b1, lat);
    chk("prio_dm_lat", 32'(lat), 32'd5);
    chk("prio_dm_data", dm_rdata, 32'h1234_5678);
    chk("prio_no_ifdone", 32'(if_done), 32'd0);
    step(); dm_req = 1'b0;
    @(negedge clk);
    chk("prio_if_a0", mem_a, 32'h104);
    wait_done(1'b0, lat);
    chk("prio_if_lat", 32'(lat), 32'd5);
    chk("prio_if_data", if_data, 32'h0010_0093);
    step(); if_req = 1'b0;

    // IO byte store throttled by io_buffer_full for 3 cycles
    step(); dm_req = 1'b1; dm_we = 1'b1; dm_size = 2'b00;
    dm_addr = 32'h0003_0000; dm_wdata = 32'hAABB_CC41; io_full = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step(); @(negedge clk);
      chk($sformatf("io_hold_wr%0d", i), 32'(mem_wr), 32'd0);
    end
    step(); io_full = 1'b0;
    @(negedge clk);
    chk("io_wr", 32'(mem_wr), 32'd1);
    chk("io_a", mem_a, 32'h0003_0000);
    chk("io_dout", 32'(mem_dout), 32'h41);
    chk("io_early_done", 32'(dm_done), 32'd0);
    step(); @(negedge clk);
    chk("io_done", 32'(dm_done), 32'd1);
    chk("io_done_wr", 32'(mem_wr), 32'd0);
    step(); dm_req = 1'b0; dm_we = 1'b0;

    // jump_flush during fetch byte 2, then a new fetch with flush still high
    w0 = wr_cnt; d0 = ifd_cnt;
    step(); if_req = 1'b1; if_addr = 32'h100;
    step(); step();
    step(); jump_flush = 1'b1;
    @(negedge clk);
    chk("flush_byte2_a", mem_a, 32'h102);
    step(); if_addr = 32'h104;
    step(); jump_flush = 1'b0;
    @(negedge clk);
    chk("flush_new_a0", mem_a, 32'h104);
    chk("flush_no_done", 32'(ifd_cnt), 32'(d0));
    wait_done(1'b0, lat);
    chk("flush_new_lat", 32'(lat), 32'd5);
    chk("flush_new_data", if_data, 32'h0010_0093);
    chk("flush_no_wr", 32'(wr_cnt), 32'(w0));
    step(); if_req = 1'b0;

    // rdy low for 4 cycles in the middle of lw 0x1000
    step(); dm_req = 1'b1; dm_we = 1'b0; dm_size = 2'b10; dm_addr = 32'h1000;
    seen = 1'b0; lat = -1;
    for (int i = 1; i <= 30 && !seen; i++) begin
      step(); rdy = !(i >= 3 && i <= 6);
      @(negedge clk);
      if (i == 3) begin
        chk("stall_a", mem_a, 32'h1001);
        chk("stall_wr", 32'(mem_wr), 32'd0);
        chk("stall_done", 32'(dm_done), 32'd0);
      end
      if (dm_done) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    chk("stall_lat", 32'(lat), 32'd10);
    chk("stall_data", dm_rdata, 32'hDEAD_BEEF);
    step(); dm_req = 1'b0; rdy = 1'b1;

    // Unaligned byte and half loads, zero-extended
    step(); dm_req = 1'b1; dm_size = 2'b00; dm_addr = 32'h1003;
    step(); @(negedge clk);
    chk("lb_a0", mem_a, 32'h1003);
    wait_done(1'b1, lat);
    chk("lb_lat", 32'(lat), 32'd2);
    chk("lb_data", dm_rdata, 32'h0000_00DE);
    step(); dm_req = 1'b0;
    step(); dm_req = 1'b1; dm_size = 2'b01; dm_addr = 32'h101;
    step(); @(negedge clk);
    chk("lh_a0", mem_a, 32'h101);
    wait_done(1'b1, lat);
    chk("lh_lat", 32'(lat), 32'd3);
    chk("lh_data", dm_rdata, 32'h0000_0005);
    step(); dm_req = 1'b0;

    // Reset during byte 1 of sw 0x2000
    step(); dm_req = 1'b1; dm_we = 1'b1; dm_size = 2'b10;
    dm_addr = 32'h2000; dm_wdata = 32'hCAFE_F00D;
    step(); @(negedge clk);
    chk("sw_b0_wr", 32'(mem_wr), 32'd1);
    chk("sw_b0_a", mem_a, 32'h2000);
    chk("sw_b0_d", 32'(mem_dout), 32'h0D);
    step(); @(negedge clk);
    chk("sw_b1_a", mem_a, 32'h2001);
    chk("sw_b1_d", 32'(mem_dout), 32'hF0);
    #2; rst = 1'b1; dm_req = 1'b0;
    #1;
    chk("rst_mid_wr", 32'(mem_wr), 32'd0);
    chk("rst_mid_a", mem_a, 32'd0);
    chk("rst_mid_done", 32'(dm_done), 32'd0);
    w0 = wr_cnt; dd0 = dmd_cnt;
    step(); rst = 1'b0;
    repeat (8) step();
    chk("rst_no_more_wr", 32'(wr_cnt), 32'(w0));
    chk("rst_no_done", 32'(dmd_cnt), 32'(dd0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
